m_wb_cached_memory: RTL
=======================

Name: m_wb_cached_memory

Overview:
- Parametrised successor to the single-beat stalling DRAM front end.
- Direct-mapped, write-back, write-allocate data cache between the CPU dmem port and the DRAM app interface (MIG or pseudo DRAM model).
- One cache line is one APP_DATA_WIDTH DRAM beat.
- Hits complete with zero stall; misses stall the CPU while an optional dirty-victim writeback and then a line refill are issued.

Parameters:
- APP_ADDR_WIDTH, 28: DRAM app byte-address width; CPU address bits above it are ignored.
- APP_DATA_WIDTH, 128: line/beat width in bits; legal values 64, 128, 256.
- APP_MASK_WIDTH, APP_DATA_WIDTH/8: DRAM byte-mask width (1 = byte not written).
- INDEX_WIDTH, 6: log2 of the number of cache lines (default 64 lines).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_dmem_ren  in  1  CPU read request.
- i_dmem_wen  in  4  CPU byte write enables; nonzero = write; write wins over read.
- i_dmem_addr  in  32  CPU byte address, 4-byte aligned.
- i_dmem_data  in  32  CPU write data.
- o_dmem_data  out  32  read data, combinational, valid when the request is not stalled.
- o_dmem_stall  out  1  CPU must hold its request stable while high.
- o_dram_ren  out  1  DRAM read command.
- o_dram_wen  out  1  DRAM write command.
- o_dram_addr  out  APP_ADDR_WIDTH-1  DRAM beat address.
- o_dram_data  out  APP_DATA_WIDTH  writeback line.
- o_dram_mask  out  APP_MASK_WIDTH  DRAM write mask.
- i_dram_calib_done  in  1  DRAM calibration complete.
- i_dram_data  in  APP_DATA_WIDTH  refill data.
- i_dram_valid  in  1  refill data valid.
- i_dram_busy  in  1  DRAM cannot accept a command.
- o_hit_count  out  32  statistics, see Optional Feature.
- o_miss_count  out  32  statistics, see Optional Feature.

Behaviour:
- Address split:
  - OFF = log2(APP_DATA_WIDTH/8).
  - word select = addr[OFF-1:2].
  - index = addr[OFF+INDEX_WIDTH-1:OFF].
  - tag = addr[APP_ADDR_WIDTH-1:OFF+INDEX_WIDTH].
  - DRAM beat address = {addr[APP_ADDR_WIDTH-1:OFF], (OFF-1) zero bits}; for 128-bit lines this is 3'b000.
- Storage per line: valid bit, dirty bit, tag, APP_DATA_WIDTH data. Register arrays; lookup is combinational.
- Reset: state=CALIB; all valid and dirty bits cleared; o_dram_ren=o_dram_wen=0; o_dram_addr/data=0; o_dram_mask all ones; counters=0.
- Reset mid-operation discards any pending DRAM response.
- req = i_dmem_ren || i_dmem_wen!=0. hit = req && valid[index] && tag match.
- o_dmem_stall = req && (state!=IDLE || !hit). The stall does not depend on i_dram_busy when state is IDLE and the access hits.
- Read hit: o_dmem_data = the selected 32-bit word in the same cycle; zero latency.
- Write hit: bytes with wen set are merged at the clock edge; dirty is set. No DRAM traffic.
- FSM states: CALIB, IDLE, WB, FILL, WAIT.
  - CALIB -> IDLE when i_dram_calib_done=1.
  - IDLE, on a miss: latch index, tag and victim info. Go to WB if the victim is valid and dirty, else to FILL.
  - WB: o_dram_wen = !i_dram_busy; addr = victim beat address; data = victim line; mask all zeros. On the cycle the command is accepted (wen && !busy), clear dirty and go to FILL.
  - FILL: o_dram_ren = !i_dram_busy; addr = the requested beat address. On acceptance go to WAIT.
  - WAIT: on i_dram_valid, write i_dram_data into the line, set valid, clear dirty, set tag, go to IDLE.
  - The held request then hits on the next cycle: a read returns data, a write merges and sets dirty.
- Commands are one-cycle pulses, and at most one command is outstanding.
- i_dram_valid outside WAIT is ignored.
- The write-then-read ordering of victim and refill addresses is safe because the two addresses differ.
- Simultaneous ren and wen: treated as a write.
- The miss penalty is therefore 1 (WB, if dirty) + 1 (FILL) + DRAM latency + 1 retry cycle, plus any i_dram_busy cycles.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined:
  - o_hit_count increments on each cycle with state==IDLE && hit.
  - o_miss_count increments on each IDLE->WB/FILL transition.
  - Both counters wrap at 2^32 and reset to 0.
  - A retry hit after a refill counts as a hit.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset, calib_done=0 for 10 cycles, ren at 0x100 -> stall=1 throughout with no DRAM commands; after calib_done=1 the read misses -> one o_dram_ren to beat address 0x100>>1 with low 3 bits 0.
- Cold read at 0x104; model returns line with word1=0xDEADBEEF -> stall drops one cycle after valid; o_dmem_data=0xDEADBEEF; an immediate read of 0x108 hits with zero stall.
- Write wen=4'b0011, data 0x0000ABCD to cached 0x104, then read 0x104 -> read returns upper bytes 0xDEAD and lower bytes 0xABCD, i.e. 0xDEADABCD; no DRAM command issued.
- Read 0x104 + (64 lines × 16 B) = 0x504 with the dirty line resident -> o_dram_wen first (mask 0, data containing 0xDEADABCD at word1), then o_dram_ren for 0x504, in that order.
- Hold i_dram_busy=1 for 5 cycles during WB and FILL -> each command stays pending, is pulsed exactly once after busy falls, and no command is duplicated.
- CACHE_STATS_EN build, 3 misses + 7 hits -> o_miss_count=3, o_hit_count=10 (the 3 retries count as hits); i_rst mid-WAIT -> counters=0, late i_dram_valid ignored, all lines invalid.

Source files
------------

// File: rtl/m_wb_cached_memory_if.sv
// rtl/m_wb_cached_memory_if.sv - CPU dmem, DRAM app and statistics signals of the cached memory
interface m_wb_cached_memory_if #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8
);
  logic                      dmem_ren;
  logic [3:0]                dmem_wen;
  logic [31:0]               dmem_addr;
  logic [31:0]               dmem_wdata;
  logic [31:0]               dmem_rdata;
  logic                      dmem_stall;
  logic                      dram_ren;
  logic                      dram_wen;
  logic [APP_ADDR_WIDTH-2:0] dram_addr;
  logic [APP_DATA_WIDTH-1:0] dram_wdata;
  logic [APP_MASK_WIDTH-1:0] dram_mask;
  logic                      dram_calib_done;
  logic [APP_DATA_WIDTH-1:0] dram_rdata;
  logic                      dram_valid;
  logic                      dram_busy;
  logic [31:0]               hit_count;
  logic [31:0]               miss_count;

  modport master (
    output dmem_ren, dmem_wen, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_stall,
    input  dram_ren, dram_wen, dram_addr, dram_wdata, dram_mask,
    output dram_calib_done, dram_rdata, dram_valid, dram_busy,
    input  hit_count, miss_count
  );

  modport slave (
    input  dmem_ren, dmem_wen, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_stall,
    output dram_ren, dram_wen, dram_addr, dram_wdata, dram_mask,
    input  dram_calib_done, dram_rdata, dram_valid, dram_busy,
    output hit_count, miss_count
  );
endinterface

// File: rtl/m_wb_cached_memory.sv
// rtl/m_wb_cached_memory.sv - direct-mapped write-back write-allocate data cache in front of DRAM
// Define CACHE_STATS_EN to build the hit/miss counters; otherwise they read as zero.
module m_wb_cached_memory #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
  parameter int INDEX_WIDTH    = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  m_wb_cached_memory_if.slave   bus
);
  localparam int OFF    = $clog2(APP_DATA_WIDTH / 8);
  localparam int LINES  = 1 << INDEX_WIDTH;
  localparam int TAG_W  = APP_ADDR_WIDTH - OFF - INDEX_WIDTH;
  localparam int WSEL_W = OFF - 2;

  typedef enum logic [2:0] {S_CALIB, S_IDLE, S_WB, S_FILL, S_WAIT} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]          valid_q;
  logic [LINES-1:0]          dirty_q;
  logic [TAG_W-1:0]          tag_mem  [LINES];
  logic [APP_DATA_WIDTH-1:0] data_mem [LINES];

  logic [INDEX_WIDTH-1:0]    idx_q;
  logic [TAG_W-1:0]          tag_q;
  logic [TAG_W-1:0]          vtag_q;

  logic [WSEL_W-1:0]         wsel;
  logic [INDEX_WIDTH-1:0]    idx;
  logic [TAG_W-1:0]          tag;
  logic [APP_DATA_WIDTH-1:0] line;
  logic                      req;
  logic                      hit;
  logic                      miss_go;
  logic                      unused_bits;

  assign wsel = bus.dmem_addr[OFF-1:2];
  assign idx  = bus.dmem_addr[OFF+INDEX_WIDTH-1:OFF];
  assign tag  = bus.dmem_addr[APP_ADDR_WIDTH-1:OFF+INDEX_WIDTH];
  assign unused_bits = &{1'b0, bus.dmem_addr[1:0], bus.dmem_addr[31:APP_ADDR_WIDTH]};

  assign line    = data_mem[idx];
  assign req     = bus.dmem_ren || (bus.dmem_wen != 4'b0000);
  assign hit     = req && valid_q[idx] && (tag_mem[idx] == tag);
  assign miss_go = (state == S_IDLE) && req && !hit;

  assign bus.dmem_stall = req && ((state != S_IDLE) || !hit);
  assign bus.dmem_rdata = line[32*int'(wsel) +: 32];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_CALIB;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CALIB: if (bus.dram_calib_done) state_nxt = S_IDLE;
      S_IDLE:  if (miss_go) state_nxt = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL;
      S_WB:    if (!bus.dram_busy) state_nxt = S_FILL;
      S_FILL:  if (!bus.dram_busy) state_nxt = S_WAIT;
      S_WAIT:  if (bus.dram_valid) state_nxt = S_IDLE;
      default: state_nxt = S_CALIB;
    endcase
  end

  // Commands are presented only while the DRAM is not busy, so each one is a single accepted pulse.
  always_comb begin
    bus.dram_ren   = 1'b0;
    bus.dram_wen   = 1'b0;
    bus.dram_addr  = '0;
    bus.dram_wdata = '0;
    bus.dram_mask  = '1;
    case (state)
      S_WB: begin
        bus.dram_wen   = !bus.dram_busy;
        bus.dram_addr  = {vtag_q, idx_q, {(OFF-1){1'b0}}};
        bus.dram_wdata = data_mem[idx_q];
        bus.dram_mask  = '0;
      end
      S_FILL: begin
        bus.dram_ren  = !bus.dram_busy;
        bus.dram_addr = {tag_q, idx_q, {(OFF-1){1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if ((state == S_IDLE) && hit && (bus.dmem_wen != 4'b0000))
        dirty_q[idx] <= 1'b1;
      if ((state == S_WB) && !bus.dram_busy)
        dirty_q[idx_q] <= 1'b0;
      if ((state == S_WAIT) && bus.dram_valid) begin
        valid_q[idx_q] <= 1'b1;
        dirty_q[idx_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (miss_go) begin
        idx_q  <= idx;
        tag_q  <= tag;
        vtag_q <= tag_mem[idx];
      end
      if ((state == S_IDLE) && hit) begin
        for (int b = 0; b < 4; b++)
          if (bus.dmem_wen[b])
            data_mem[idx][32*int'(wsel) + 8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
      end
      if ((state == S_WAIT) && bus.dram_valid) begin
        data_mem[idx_q] <= bus.dram_rdata;
        tag_mem[idx_q]  <= tag_q;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && hit) hit_cnt <= hit_cnt + 32'd1;
      if (miss_go)                  miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
`else
  assign bus.hit_count  = 32'd0;
  assign bus.miss_count = 32'd0;
`endif
endmodule
